// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the parametrised direct-mapped data cache.
// Widths of the address fields are derived here so top and store agree on them.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic bit isPow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int tagWidth(input int addrW, input int wordsPerBlock, input int numSets);
    return addrW - clog2(wordsPerBlock) - clog2(numSets);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage for the cache: data, tag, valid and dirty arrays sharing one index.
// Data and tag arrays carry no reset; only valid/dirty are cleared asynchronously.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  parameter int TAG_W           = 3,
  localparam int OFFSET_W       = clog2(WORDS_PER_BLOCK),
  localparam int INDEX_W        = clog2(NUM_SETS)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [INDEX_W-1:0]                        i_index,
  input  logic [OFFSET_W-1:0]                       i_offset,
  input  logic                                      i_word_we,
  input  logic [DATA_W-1:0]                         i_word_data,
  input  logic                                      i_line_we,
  input  logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0]    i_line_data,
  input  logic [TAG_W-1:0]                          i_line_tag,
  output logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0]    o_line,
  output logic [TAG_W-1:0]                          o_tag,
  output logic                                      o_valid,
  output logic                                      o_dirty
);

  logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] r_data [NUM_SETS];
  logic [TAG_W-1:0]                       r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0]                    r_valid;
  logic [NUM_SETS-1:0]                    r_dirty;

  // A refill replaces the whole line; otherwise a store patches one word.
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_data[i_index] <= i_line_data;
      r_tag[i_index]  <= i_line_tag;
    end else if (i_word_we) begin
      r_data[i_index][i_offset] <= i_word_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  assign o_line  = r_data[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];

endmodule

// File: rtl/dcache_param.sv
// Direct-mapped write-back, write-allocate data cache between the CPU data port and
// a block-wide memory, with saturating hit/miss counters.
module dcache_param
  import dcache_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8,
  parameter int CNT_W           = 16,
  localparam int OFFSET_W       = clog2(WORDS_PER_BLOCK),
  localparam int INDEX_W        = clog2(NUM_SETS),
  localparam int TAG_W          = tagWidth(ADDR_W, WORDS_PER_BLOCK, NUM_SETS),
  localparam int BLOCK_W        = DATA_W * WORDS_PER_BLOCK
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [DATA_W-1:0]          WRITEDATA,
  output logic [DATA_W-1:0]          READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT,
  output logic [CNT_W-1:0]           HIT_COUNT,
  output logic [CNT_W-1:0]           MISS_COUNT
);

  if (TAG_W < 1 || !isPow2(WORDS_PER_BLOCK) || !isPow2(NUM_SETS)) begin : g_bad_geometry
    $error("dcache_param: invalid cache geometry");
  end

  state_e                                 r_state;
  logic                                   r_first;
  logic                                   r_refill;
  logic                                   r_mem_read;
  logic                                   r_mem_write;
  logic [CNT_W-1:0]                       r_hit_cnt;
  logic [CNT_W-1:0]                       r_miss_cnt;

  logic [TAG_W-1:0]                       w_tag;
  logic [INDEX_W-1:0]                     w_index;
  logic [OFFSET_W-1:0]                    w_offset;
  logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] w_line;
  logic [TAG_W-1:0]                       w_stored_tag;
  logic                                   w_valid;
  logic                                   w_dirty;
  logic                                   w_in_idle;
  logic                                   w_req;
  logic                                   w_hit;
  logic                                   w_word_we;
  logic                                   w_line_we;
  logic                                   w_done;

  assign w_tag     = ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_index   = ADDRESS[OFFSET_W +: INDEX_W];
  assign w_offset  = ADDRESS[OFFSET_W-1:0];
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_req     = READ | WRITE;
  assign w_hit     = w_in_idle & w_valid & (w_stored_tag == w_tag);
  assign w_word_we = w_hit & WRITE;
  assign w_line_we = (r_state == ST_UPDATE);
  // Memory handshake is only trusted from the second cycle of a memory state.
  assign w_done    = ~r_first & ~MEM_BUSYWAIT;

  dcache_store #(
    .DATA_W          (DATA_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .NUM_SETS        (NUM_SETS),
    .TAG_W           (TAG_W)
  ) u_store (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_index     (w_index),
    .i_offset    (w_offset),
    .i_word_we   (w_word_we),
    .i_word_data (WRITEDATA),
    .i_line_we   (w_line_we),
    .i_line_data (MEM_READDATA),
    .i_line_tag  (w_tag),
    .o_line      (w_line),
    .o_tag       (w_stored_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty)
  );

  // A refilled access finishes as a hit in IDLE but is counted only as a miss.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_first     <= 1'b0;
      r_refill    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (r_refill) r_refill <= 1'b0;
              else if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
              r_first <= 1'b1;
              if (w_dirty) begin
                r_state     <= ST_WRITEBACK;
                r_mem_write <= 1'b1;
              end else begin
                r_state    <= ST_FETCH;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        ST_WRITEBACK: begin
          r_first <= 1'b0;
          if (w_done) begin
            r_state     <= ST_FETCH;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_first     <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_first <= 1'b0;
          if (w_done) begin
            r_state    <= ST_UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        ST_UPDATE: begin
          r_refill <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSYWAIT      = w_in_idle ? (w_req & ~w_hit) : 1'b1;
  assign READDATA      = w_line[w_offset];
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = (r_state == ST_WRITEBACK) ? {w_stored_tag, w_index} : {w_tag, w_index};
  assign MEM_WRITEDATA = w_line;
  assign HIT_COUNT     = r_hit_cnt;
  assign MISS_COUNT    = r_miss_cnt;

endmodule

// File: tb/tb_dcache_param.sv
// Directed bench for dcache_param: hit vectors from a table, hand sequences for misses,
// writeback, reset during a fill, minimum-latency timing and counter saturation.
module tb_dcache_param;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        expBusy;
    logic [7:0]  expData;
    logic [15:0] expHit;
    logic [15:0] expMiss;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        cpuRead = 1'b0, cpuWrite = 1'b0;
  logic [7:0]  cpuAddr = 8'h00, cpuWData = 8'h00;
  logic [7:0]  cpuRData;
  logic        busyWait, memRead, memWrite, memBusy;
  logic [5:0]  memAddr;
  logic [31:0] memWData, memRData;
  logic [31:0] memFill = 32'h0;
  logic [15:0] hitCount, missCount;

  logic        sRead = 1'b0, sWrite = 1'b0, sMemBusy = 1'b0;
  logic [7:0]  sAddr = 8'h00, sWData = 8'h00;
  logic [7:0]  sRData;
  logic        sBusy, sMemRead, sMemWrite;
  logic [5:0]  sMemAddr;
  logic [31:0] sMemWData;
  logic [31:0] sMemRData = 32'h04030201;
  logic [1:0]  sHit, sMiss;

  logic [1:0]  memKind, seenKind;
  int          memCnt, curCnt, memLat;
  int          checks = 0, failures = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  dcache_param dut (
    .CLK(clk), .RESET(rstN), .READ(cpuRead), .WRITE(cpuWrite), .ADDRESS(cpuAddr),
    .WRITEDATA(cpuWData), .READDATA(cpuRData), .BUSYWAIT(busyWait),
    .MEM_READ(memRead), .MEM_WRITE(memWrite), .MEM_ADDRESS(memAddr),
    .MEM_WRITEDATA(memWData), .MEM_READDATA(memRData), .MEM_BUSYWAIT(memBusy),
    .HIT_COUNT(hitCount), .MISS_COUNT(missCount)
  );

  dcache_param #(.CNT_W(2)) dutSat (
    .CLK(clk), .RESET(rstN), .READ(sRead), .WRITE(sWrite), .ADDRESS(sAddr),
    .WRITEDATA(sWData), .READDATA(sRData), .BUSYWAIT(sBusy),
    .MEM_READ(sMemRead), .MEM_WRITE(sMemWrite), .MEM_ADDRESS(sMemAddr),
    .MEM_WRITEDATA(sMemWData), .MEM_READDATA(sMemRData), .MEM_BUSYWAIT(sMemBusy),
    .HIT_COUNT(sHit), .MISS_COUNT(sMiss)
  );

  // Memory stays busy for memLat cycles of each new request, then reports completion.
  assign memKind  = {memRead, memWrite};
  assign memRData = memFill;
  always_comb begin
    curCnt  = (memKind == seenKind) ? memCnt : 0;
    memBusy = (memKind != 2'b00) && (curCnt < memLat);
  end
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      seenKind <= 2'b00;
      memCnt   <= 0;
    end else begin
      seenKind <= memKind;
      memCnt   <= (memKind != 2'b00) ? curCnt + 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    cpuRead  = rd;
    cpuWrite = wr;
    cpuAddr  = addr;
    cpuWData = wdata;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitHit(output int busyCycles, output int rdCycles, output int wrCycles);
    busyCycles = 0;
    rdCycles   = 0;
    wrCycles   = 0;
    for (int i = 0; i < 64 && busyWait; i++) begin
      busyCycles++;
      if (memRead) rdCycles++;
      if (memWrite) wrCycles++;
      step();
    end
    checkOutput("waitHit busywait released", 32'(busyWait), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busyC, rdC, wrC, wbSteps;
    vecs[0] = '{1'b0, 1'b1, 8'h15, 8'hAB, 1'b0, 8'h22, 16'd0, 16'd1};
    vecs[1] = '{1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 8'hAB, 16'd1, 16'd1};
    vecs[2] = '{1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 8'h11, 16'd2, 16'd1};
    vecs[3] = '{1'b1, 1'b0, 8'h17, 8'h00, 1'b0, 8'h44, 16'd3, 16'd1};
    vecs[4] = '{1'b1, 1'b0, 8'h16, 8'h00, 1'b0, 8'h33, 16'd4, 16'd1};
    vecs[5] = '{1'b0, 1'b0, 8'h16, 8'h00, 1'b0, 8'h33, 16'd5, 16'd1};
    memLat  = 3;
    memFill = 32'h44332211;

    #2 rstN = 1'b0;
    #1;
    checkOutput("reset busywait idle", 32'(busyWait), 32'd0);
    checkOutput("reset mem_read", 32'(memRead), 32'd0);
    checkOutput("reset mem_write", 32'(memWrite), 32'd0);
    checkOutput("reset hit_count", 32'(hitCount), 32'd0);
    checkOutput("reset miss_count", 32'(missCount), 32'd0);
    cpuRead = 1'b1;
    #1;
    checkOutput("reset busywait with read", 32'(busyWait), 32'd1);
    cpuRead = 1'b0;
    step();
    rstN = 1'b1;
    step();

    // Clean miss with a slow memory.
    applyStimulus(1'b1, 1'b0, 8'h14, 8'h00);
    #1;
    checkOutput("miss busywait", 32'(busyWait), 32'd1);
    checkOutput("miss no mem_read yet", 32'(memRead), 32'd0);
    step();
    checkOutput("fetch miss_count", 32'(missCount), 32'd1);
    checkOutput("fetch mem_read", 32'(memRead), 32'd1);
    checkOutput("fetch mem_write", 32'(memWrite), 32'd0);
    checkOutput("fetch mem_address", 32'(memAddr), 32'h05);
    waitHit(busyC, rdC, wrC);
    checkOutput("fill busy cycles", 32'(busyC), 32'd5);
    checkOutput("fill fetch cycles", 32'(rdC), 32'd4);
    checkOutput("fill readdata", 32'(cpuRData), 32'h11);
    checkOutput("fill hit_count", 32'(hitCount), 32'd0);
    step();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("vec%0d busywait", i), 32'(busyWait), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d readdata", i), 32'(cpuRData), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d hit_count", i), 32'(hitCount), 32'(vecs[i].expHit));
      checkOutput($sformatf("vec%0d miss_count", i), 32'(missCount), 32'(vecs[i].expMiss));
      checkOutput($sformatf("vec%0d mem_read", i), 32'(memRead), 32'd0);
      checkOutput($sformatf("vec%0d mem_write", i), 32'(memWrite), 32'd0);
      step();
    end

    // Dirty conflict miss: writeback of the old line, then fetch, then reset mid-fetch.
    memFill = 32'hDDCCBBAA;
    applyStimulus(1'b1, 1'b0, 8'h94, 8'h00);
    #1;
    checkOutput("conflict busywait", 32'(busyWait), 32'd1);
    checkOutput("conflict readdata index", 32'(cpuRData), 32'h11);
    step();
    checkOutput("wb mem_write", 32'(memWrite), 32'd1);
    checkOutput("wb mem_read", 32'(memRead), 32'd0);
    checkOutput("wb mem_address", 32'(memAddr), 32'h05);
    checkOutput("wb mem_writedata", memWData, 32'h4433AB11);
    checkOutput("wb miss_count", 32'(missCount), 32'd2);
    wbSteps = 0;
    for (int i = 0; i < 20 && !memRead; i++) begin
      step();
      wbSteps++;
    end
    checkOutput("wb2fetch mem_read", 32'(memRead), 32'd1);
    checkOutput("wb cycles", 32'(wbSteps), 32'd4);
    checkOutput("wb2fetch mem_write", 32'(memWrite), 32'd0);
    checkOutput("wb2fetch mem_address", 32'(memAddr), 32'h25);
    step();
    checkOutput("mid fetch mem_read", 32'(memRead), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("async reset mem_read", 32'(memRead), 32'd0);
    checkOutput("async reset mem_write", 32'(memWrite), 32'd0);
    checkOutput("async reset hit_count", 32'(hitCount), 32'd0);
    checkOutput("async reset miss_count", 32'(missCount), 32'd0);
    checkOutput("async reset busywait", 32'(busyWait), 32'd1);
    #1 rstN = 1'b1;
    step();
    checkOutput("refetch mem_read", 32'(memRead), 32'd1);
    checkOutput("refetch no writeback", 32'(memWrite), 32'd0);
    checkOutput("refetch mem_address", 32'(memAddr), 32'h25);
    checkOutput("refetch miss_count", 32'(missCount), 32'd1);
    waitHit(busyC, rdC, wrC);
    checkOutput("refetch busy cycles", 32'(busyC), 32'd5);
    checkOutput("refetch wb cycles", 32'(wrC), 32'd0);
    checkOutput("refetch readdata", 32'(cpuRData), 32'hAA);
    checkOutput("refetch hit_count", 32'(hitCount), 32'd0);
    step();

    // READ and WRITE together: the store wins.
    applyStimulus(1'b1, 1'b1, 8'h95, 8'h5A);
    #1;
    checkOutput("rw busywait", 32'(busyWait), 32'd0);
    checkOutput("rw readdata before", 32'(cpuRData), 32'hBB);
    step();
    applyStimulus(1'b1, 1'b0, 8'h95, 8'h00);
    #1;
    checkOutput("rw readdata after", 32'(cpuRData), 32'h5A);
    checkOutput("rw hit_count", 32'(hitCount), 32'd1);
    step();

    // Zero-latency memory: every memory state lasts exactly two cycles.
    memLat  = 0;
    memFill = 32'h87654321;
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    waitHit(busyC, rdC, wrC);
    checkOutput("fast clean busy cycles", 32'(busyC), 32'd4);
    checkOutput("fast clean fetch cycles", 32'(rdC), 32'd2);
    checkOutput("fast clean wb cycles", 32'(wrC), 32'd0);
    checkOutput("fast clean readdata", 32'(cpuRData), 32'h21);
    step();
    applyStimulus(1'b0, 1'b1, 8'h21, 8'h77);
    #1;
    checkOutput("fast store busywait", 32'(busyWait), 32'd0);
    step();
    memFill = 32'h0F0E0D0C;
    applyStimulus(1'b1, 1'b0, 8'hA0, 8'h00);
    #1;
    waitHit(busyC, rdC, wrC);
    checkOutput("fast dirty busy cycles", 32'(busyC), 32'd6);
    checkOutput("fast dirty fetch cycles", 32'(rdC), 32'd2);
    checkOutput("fast dirty wb cycles", 32'(wrC), 32'd2);
    checkOutput("fast dirty readdata", 32'(cpuRData), 32'h0C);
    checkOutput("fast dirty miss_count", 32'(missCount), 32'd3);
    checkOutput("fast dirty hit_count", 32'(hitCount), 32'd3);
    step();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    // Two-bit counters saturate at 3.
    sRead = 1'b1;
    sAddr = 8'h14;
    #1;
    for (int i = 0; i < 20 && sBusy; i++) step();
    checkOutput("sat fill done", 32'(sBusy), 32'd0);
    checkOutput("sat readdata", 32'(sRData), 32'h01);
    checkOutput("sat refill hit_count", 32'(sHit), 32'd0);
    checkOutput("sat miss_count", 32'(sMiss), 32'd1);
    step();
    step();
    step();
    checkOutput("sat two hits", 32'(sHit), 32'd2);
    step();
    step();
    step();
    checkOutput("sat five hits", 32'(sHit), 32'd3);
    checkOutput("sat mem_read", 32'(sMemRead), 32'd0);
    checkOutput("sat mem_write", 32'(sMemWrite), 32'd0);
    checkOutput("sat mem_address", 32'(sMemAddr), 32'h05);
    checkOutput("sat line", sMemWData, 32'h04030201);
    sRead = 1'b0;
    sWrite = 1'b0;
    sWData = 8'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
